// File: rtl/snake_food_manager.sv
// Snake food manager: tracks NUM_FOOD items, detects the head eating one on each
// game tick, scores it and respawns the eaten item at an LFSR-chosen free cell.
module snake_food_manager #(
    parameter int          COORD_W   = 6,
    parameter int          GRID_W    = 40,
    parameter int          GRID_H    = 30,
    parameter int          NUM_FOOD  = 2,
    parameter int          TICK_DIV  = 250000,
    parameter int          SCORE_W   = 16,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        en,
    input  logic [COORD_W-1:0]          head_x,
    input  logic [COORD_W-1:0]          head_y,
    output logic [NUM_FOOD*COORD_W-1:0] food_x,
    output logic [NUM_FOOD*COORD_W-1:0] food_y,
    output logic [NUM_FOOD-1:0]         food_valid,
    output logic                        add_length,
    output logic [SCORE_W-1:0]          score,
    output logic                        busy
);

    if (!(GRID_W >= 4 && GRID_W <= 2**COORD_W && GRID_H >= 4 && GRID_H <= 2**COORD_W &&
          2*COORD_W <= 16 && NUM_FOOD >= 1 && TICK_DIV >= 2 && LFSR_SEED != 16'h0))
    begin : g_param_err
        $error("snake_food_manager: illegal parameter combination");
    end

    localparam int                 CNT_W    = $clog2(TICK_DIV);
    localparam int                 IDX_W    = (NUM_FOOD > 1) ? $clog2(NUM_FOOD) : 1;
    localparam logic [CNT_W-1:0]   CNT_MAX  = CNT_W'(TICK_DIV - 1);
    localparam logic [15:0]        LFSR_TAP = 16'hB400;  // x^16+x^14+x^13+x^11+1
    localparam logic [COORD_W-1:0] C_ONE    = COORD_W'(1);
    localparam logic [COORD_W-1:0] X_MAX    = COORD_W'(GRID_W - 2);
    localparam logic [COORD_W-1:0] Y_MAX    = COORD_W'(GRID_H - 2);

    typedef enum logic [1:0] {S_IDLE, S_CHECK, S_RESPAWN} state_t;

    state_t                             r_state;
    logic [CNT_W-1:0]                   r_cnt;
    logic [15:0]                        r_lfsr;
    logic [NUM_FOOD-1:0][COORD_W-1:0]   r_fx;
    logic [NUM_FOOD-1:0][COORD_W-1:0]   r_fy;
    logic [NUM_FOOD-1:0]                r_fv;
    logic [IDX_W-1:0]                   r_slot;
    logic                               r_add;
    logic [SCORE_W-1:0]                 r_score;
    logic                               r_busy;

    logic                               w_tick;
    logic                               w_hit;
    logic [IDX_W-1:0]                   w_hit_idx;
    logic [COORD_W-1:0]                 w_cx;
    logic [COORD_W-1:0]                 w_cy;
    logic                               w_clash;
    logic                               w_accept;

    assign food_x     = r_fx;
    assign food_y     = r_fy;
    assign food_valid = r_fv;
    assign add_length = r_add;
    assign score      = r_score;
    assign busy       = r_busy;

    assign w_tick = en && (r_cnt == CNT_MAX);
    assign w_cx   = r_lfsr[COORD_W-1:0];
    assign w_cy   = r_lfsr[2*COORD_W-1:COORD_W];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_lfsr <= LFSR_SEED;
        else     r_lfsr <= (r_lfsr >> 1) ^ (r_lfsr[0] ? LFSR_TAP : 16'h0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)     r_cnt <= '0;
        else if (en) r_cnt <= (r_cnt == CNT_MAX) ? '0 : r_cnt + 1'b1;
    end

    // Descending scan so the lowest matching index wins.
    always_comb begin
        w_hit     = 1'b0;
        w_hit_idx = '0;
        for (int i = NUM_FOOD - 1; i >= 0; i--) begin
            if (r_fv[i] && r_fx[i] == head_x && r_fy[i] == head_y) begin
                w_hit     = 1'b1;
                w_hit_idx = IDX_W'(i);
            end
        end
    end

    // The slot being respawned is already invalid, so it never clashes with itself.
    always_comb begin
        w_clash = 1'b0;
        for (int i = 0; i < NUM_FOOD; i++)
            if (r_fv[i] && r_fx[i] == w_cx && r_fy[i] == w_cy) w_clash = 1'b1;
        w_accept = (w_cx >= C_ONE) && (w_cx <= X_MAX) &&
                   (w_cy >= C_ONE) && (w_cy <= Y_MAX) &&
                   !(w_cx == head_x && w_cy == head_y) && !w_clash;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_add   <= 1'b0;
            r_score <= '0;
            r_busy  <= 1'b0;
            r_slot  <= '0;
            r_fv    <= '1;
            for (int i = 0; i < NUM_FOOD; i++) begin
                r_fx[i] <= COORD_W'((GRID_W * (i + 1)) / (NUM_FOOD + 1));
                r_fy[i] <= COORD_W'(GRID_H / 3);
            end
        end else begin
            r_add <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_tick) begin
                        r_state <= S_CHECK;
                        r_busy  <= 1'b1;
                    end
                end
                S_CHECK: begin
                    if (w_hit) begin
                        r_add           <= 1'b1;
                        r_score         <= (&r_score) ? r_score : r_score + 1'b1;
                        r_fv[w_hit_idx] <= 1'b0;
                        r_slot          <= w_hit_idx;
                        r_state         <= S_RESPAWN;
                    end else begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                S_RESPAWN: begin
                    if (w_accept) begin
                        r_fx[r_slot] <= w_cx;
                        r_fy[r_slot] <= w_cy;
                        r_fv[r_slot] <= 1'b1;
                        r_state      <= S_IDLE;
                        r_busy       <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/snake_food_manager.md
SNAKE_FOOD_MANAGER -- requirements
Module: snake_food_manager

Interface
REQ-001 SHALL provide parameter COORD_W, default 6: width of one coordinate.
REQ-002 SHALL provide parameter GRID_W, default 40: playfield columns; column 0 and column GRID_W-1 are walls.
REQ-003 SHALL provide parameter GRID_H, default 30: playfield rows; row 0 and row GRID_H-1 are walls.
REQ-004 SHALL provide parameter NUM_FOOD, default 2: number of simultaneous food items.
REQ-005 SHALL provide parameter TICK_DIV, default 250000: clk cycles per game-check tick.
REQ-006 SHALL provide parameter SCORE_W, default 16: score counter width.
REQ-007 SHALL provide parameter LFSR_SEED, default 16'hACE1: LFSR reset value; must be nonzero.
REQ-008 SHALL enforce these legal ranges: 4<=GRID_W<=2**COORD_W; 4<=GRID_H<=2**COORD_W; 2*COORD_W<=16; NUM_FOOD>=1; TICK_DIV>=2.
REQ-009 SHALL provide port clk, input, 1 bit: clock.
REQ-010 SHALL provide port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-011 SHALL provide port en, input, 1 bit: game running; low = paused.
REQ-012 SHALL provide ports head_x and head_y, input, COORD_W bits each: snake head position.
REQ-013 SHALL provide ports food_x and food_y, output, NUM_FOOD*COORD_W bits each: item i occupies bits [i*COORD_W +: COORD_W].
REQ-014 SHALL provide port food_valid, output, NUM_FOOD bits: item i currently placed.
REQ-015 SHALL provide port add_length, output, 1 bit: one-cycle grow pulse.
REQ-016 SHALL provide port score, output, SCORE_W bits: food eaten.
REQ-017 SHALL provide port busy, output, 1 bit: a check or respawn is in progress.

Function
REQ-018 SHALL run a 16-bit Galois LFSR, polynomial x^16+x^14+x^13+x^11+1, advancing every clk cycle regardless of en or FSM state.
REQ-019 SHALL run a tick counter 0..TICK_DIV-1 that advances only when en=1, wraps to 0, and holds its value when en=0.
REQ-020 SHALL raise an internal tick when the counter equals TICK_DIV-1 and en=1.
REQ-021 SHALL implement an FSM with states IDLE, CHECK and RESPAWN; busy=1 in CHECK and RESPAWN.
REQ-022 IDLE: on tick go to CHECK; ticks arriving outside IDLE SHALL be dropped, not queued.
REQ-023 CHECK (one cycle): hit = lowest index i with food_valid[i]=1 and food_x[i]==head_x and food_y[i]==head_y; if no hit, return to IDLE.
REQ-024 On hit, at the edge leaving CHECK: add_length=1 for exactly one cycle; score+1, saturating at all-ones; food_valid[i]=0; latch i; go to RESPAWN.
REQ-025 RESPAWN, each cycle: candidate x=lfsr[COORD_W-1:0], y=lfsr[2*COORD_W-1:COORD_W].
REQ-026 Accept the candidate only if all hold: 1<=x<=GRID_W-2; 1<=y<=GRID_H-2; (x,y)!=(head_x,head_y); (x,y) differs from every other valid item.
REQ-027 On accept: write the latched item's coordinates, set its food_valid, go to IDLE.
REQ-028 On reject: remain in RESPAWN with no clamping or subtraction; the next LFSR value is tried.
REQ-029 Inputs head_x/head_y SHALL be sampled live each cycle, not latched.
REQ-030 en=0 SHALL NOT abort a CHECK or RESPAWN already in progress.
REQ-031 add_length SHALL be 0 in every cycle other than the one defined in REQ-024.

Reset
REQ-032 On rst: state IDLE; tick counter 0; LFSR=LFSR_SEED; score 0; add_length 0; busy 0; food_valid all 1.
REQ-033 On rst, item i SHALL be placed at food_x=(GRID_W*(i+1))/(NUM_FOOD+1), food_y=GRID_H/3; defaults give (13,10) and (26,10).
REQ-034 rst mid-RESPAWN SHALL immediately restore all REQ-032/033 values; the pending respawn is discarded.

Verification (TICK_DIV=4 unless noted)
REQ-035 Release rst, en=0 -> food (13,10),(26,10); food_valid=2'b11; score=0; busy=0; stable over 50 cycles.
REQ-036 head=(13,10), en=1 -> tick on 4th enabled cycle; next edge: add_length one cycle, score=1, food_valid=2'b10; then food0 lands in [1..38]x[1..28], not (13,10) or (26,10); food_valid=2'b11; busy falls.
REQ-037 head=(26,10) -> only item 1 respawns; item 0 unchanged; score=1.
REQ-038 head=(5,5), no food there -> no add_length, score unchanged, busy high exactly 1 cycle per tick.
REQ-039 SCORE_W=2, head driven onto each freshly respawned item 5 times -> score 1,2,3,3,3; add_length pulses 5 times.
REQ-040 head on food, en=0 for 20 cycles -> no pulse; raise en -> hit on the 4th enabled cycle; rst during RESPAWN -> REQ-032/033 values on the next sample.
